approximate_multiplier: RTL and testbench
=========================================

APPROXIMATE_MULTIPLIER -- requirements
Module: approximate_multiplier

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 16, operand width in bits; legal values 4, 8 and 16 (power of two, ≥4).
REQ-002 The port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates on its rising edge.
REQ-003 The port rst SHALL be an input, 1 bit wide, and is an asynchronous, active-high reset.
REQ-004 The port in_valid SHALL be an input, 1 bit wide, and qualifies a and b in the current cycle.
REQ-005 The port a SHALL be an input, WIDTH bits wide, and is the unsigned multiplicand.
REQ-006 The port b SHALL be an input, WIDTH bits wide, and is the unsigned multiplier.
REQ-007 The port out_valid SHALL be an output, 1 bit wide, and marks res as holding a new product.
REQ-008 The port res SHALL be an output, 2*WIDTH bits wide, and is the registered approximate product.

Function
REQ-009 Operands SHALL be split into base-4 digits: a_i = a[2i+1:2i] and b_j = b[2j+1:2j], for i, j = 0..WIDTH/2-1.
REQ-010 Each digit pair SHALL produce K(a_i,b_j), where K(x,y) = x*y exactly, except K(3,3) = 7 (3-bit result; 0b111 instead of 0b1001).
REQ-011 The approximate product SHALL equal the sum over all i, j of K(a_i,b_j) << 2(i+j), computed with exact adders and no truncation, to 2*WIDTH bits.
REQ-012 Consequence: the result SHALL equal a*b exactly whenever no position has both digits equal to 3; otherwise the result is below a*b by 2·Σ 4^(i+j) over the (3,3) pairs, and never exceeds a*b.
REQ-013 Latency SHALL be exactly 1 cycle: on a rising edge with in_valid=1, res takes the product of the sampled a and b, and out_valid becomes 1.
REQ-014 On a rising edge with in_valid=0, res SHALL hold its previous value and out_valid SHALL become 0.
REQ-015 The block SHALL accept one operation per cycle with no back-pressure; back-to-back in_valid pulses produce back-to-back results in order.
REQ-016 The datapath from a/b to the res register SHALL be purely combinational, with no internal pipeline stages.

Reset
REQ-017 While rst=1, res SHALL be 0 and out_valid SHALL be 0, immediately and independent of clk.
REQ-018 If rst is asserted in the same cycle as in_valid, that operation SHALL be discarded.
REQ-019 The first rising edge after rst deasserts SHALL behave per REQ-013/REQ-014.

Structure
REQ-020 A shared package SHALL hold the default WIDTH constant and the function or constant table defining K.
REQ-021 There SHALL be one sub-module, approx_mul_2x2, inputs x[1:0] and y[1:0], output p[2:0], implementing K.
REQ-022 The top level SHALL generate (WIDTH/2)^2 instances of approx_mul_2x2, plus a shifted-sum adder tree and the output register.

Verification
REQ-023 Scenario: a=0xA0A0, b=0x0A0A, in_valid=1 -> next cycle res=0x064C8640 (105678400, exact), out_valid=1.
REQ-024 Scenario: a=0xFFFF, b=0xFFFF -> res=0xC71AE38F (3340428175; exact 0xFFFE0001).
REQ-025 Scenario: a=0x0E01, b=0x0008 -> res=0x00007008 (28680, exact); then a=0x0004, b=0x0002 -> res=8.
REQ-026 Scenario: a=0x0003, b=0x0003 -> res=7; then a=0x000F, b=0x000F -> res=175 (exact 225).
REQ-027 Scenario: drive in_valid=0 after a valid op -> out_valid=0 and res unchanged; assert rst asynchronously mid-stream -> res=0 and out_valid=0 without a clock edge.
REQ-028 Scenario: random back-to-back operands -> every res matches a reference model of REQ-011, and res ≤ a*b.

Source files
------------

// File: rtl/approximate_multiplier_pkg.sv
// Shared constants and the 2-bit digit product definition for the approximate multiplier.
package approximate_multiplier_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  // Exact 2x2 product except 3*3, which saturates to the 3-bit value 7.
  function automatic logic [2:0] approx_k(input logic [1:0] x, input logic [1:0] y);
    logic [3:0] prod;
    prod = 4'(x) * 4'(y);
    if (x == 2'd3 && y == 2'd3) begin
      return 3'd7;
    end
    return prod[2:0];
  endfunction

endpackage

// File: rtl/approximate_multiplier_approx_mul_2x2.sv
// Approximate 2-bit by 2-bit multiplier cell with a 3-bit product.
module approx_mul_2x2
  import approximate_multiplier_pkg::*;
(
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic [2:0] p
);

  assign p = approx_k(x, y);

endmodule

// File: rtl/approximate_multiplier.sv
// Unsigned approximate multiplier: base-4 digit products summed exactly, one registered stage.
module approximate_multiplier
  import approximate_multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] res
);

  localparam int unsigned DIGITS = WIDTH / 2;
  localparam int unsigned PW     = 2 * WIDTH;

  logic [2:0]    pp [DIGITS*DIGITS];
  logic [PW-1:0] row_sum [DIGITS];
  logic [PW-1:0] sum;

  for (genvar i = 0; i < DIGITS; i++) begin : g_row
    for (genvar j = 0; j < DIGITS; j++) begin : g_col
      approx_mul_2x2 u_cell (
        .x (a[2*i+1:2*i]),
        .y (b[2*j+1:2*j]),
        .p (pp[i*DIGITS+j])
      );
    end
  end

  // Each row sums the partial products of one a-digit, then rows are weighted by that digit's position.
  always_comb begin
    for (int unsigned i = 0; i < DIGITS; i++) begin
      row_sum[i] = '0;
      for (int unsigned j = 0; j < DIGITS; j++) begin
        row_sum[i] = row_sum[i] + (PW'(pp[i*DIGITS+j]) << (2*j));
      end
    end
  end

  always_comb begin
    sum = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      sum = sum + (row_sum[i] << (2*i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        res <= sum;
      end
    end
  end

endmodule

// File: tb/tb_approximate_multiplier.sv
// Directed and random checks of the approximate multiplier against hand values and a digit model.
module tb_approximate_multiplier;

  localparam int unsigned W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic [W-1:0]   a = '0;
  logic [W-1:0]   b = '0;
  logic           out_valid;
  logic [2*W-1:0] res;

  int unsigned checks = 0;
  int unsigned failures = 0;

  approximate_multiplier #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .res       (res)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [63:0] acc;
    logic [1:0]  dx, dy;
    logic [63:0] k;
    acc = 0;
    for (int i = 0; i < W/2; i++) begin
      for (int j = 0; j < W/2; j++) begin
        dx = x[2*i +: 2];
        dy = y[2*j +: 2];
        k  = (dx == 2'd3 && dy == 2'd3) ? 64'd7 : 64'(dx) * 64'(dy);
        acc = acc + (k << (2*(i+j)));
      end
    end
    return acc[2*W-1:0];
  endfunction

  task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [63:0] expected);
    @(negedge clk);
    in_valid = 1'b1;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    check({tag, ".valid"}, 64'(out_valid), 64'd1);
    check({tag, ".res"}, 64'(res), expected);
  endtask

  task automatic idle(input string tag, input logic [63:0] held);
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'h1234;
    b = 16'h5678;
    @(posedge clk);
    #1;
    check({tag, ".valid"}, 64'(out_valid), 64'd0);
    check({tag, ".hold"}, 64'(res), held);
  endtask

  initial begin
    logic [W-1:0]   ra, rb;
    logic [2*W-1:0] exp_r;

    #1;
    check("reset.res", 64'(res), 64'd0);
    check("reset.valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op("exact_a0a0", 16'hA0A0, 16'h0A0A, 64'h064C8640);
    do_op("all_ones", 16'hFFFF, 16'hFFFF, 64'hC71AE38F);
    do_op("exact_0e01", 16'h0E01, 16'h0008, 64'h00007008);
    do_op("small_4x2", 16'h0004, 16'h0002, 64'd8);
    do_op("digit_3x3", 16'h0003, 16'h0003, 64'd7);
    do_op("f_x_f", 16'h000F, 16'h000F, 64'd175);
    do_op("zero_a", 16'h0000, 16'hFFFF, 64'd0);
    do_op("top_digits", 16'hC000, 16'hC000, 64'h70000000);
    idle("idle1", 64'd175 + 64'h70000000 - 64'd175);
    idle("idle2", 64'h70000000);

    // Asynchronous reset between clock edges.
    do_op("pre_rst", 16'h0002, 16'h0003, 64'd6);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst.res", 64'(res), 64'd0);
    check("async_rst.valid", 64'(out_valid), 64'd0);

    // An operation presented during reset is discarded.
    in_valid = 1'b1;
    a = 16'h0010;
    b = 16'h0010;
    @(posedge clk);
    #1;
    check("rst_discard.res", 64'(res), 64'd0);
    check("rst_discard.valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_idle.valid", 64'(out_valid), 64'd0);
    check("post_rst_idle.res", 64'(res), 64'd0);
    do_op("post_rst_op", 16'h0010, 16'h0010, 64'h100);

    for (int n = 0; n < 60; n++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (n % 4 == 0) ra = ra | 16'h3333;
      exp_r = model(ra, rb);
      do_op("rand", ra, rb, 64'(exp_r));
      check("rand.le", 64'(64'(res) <= 64'(ra) * 64'(rb)), 64'd1);
    end

    @(negedge clk);
    in_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
